// File: rtl/plate_pkg.sv
// plate_pkg: shared plate geometry and character-field helper
package plate_pkg;

    localparam int PLATE_CHARS = 7;
    localparam int CHAR_W      = 4;
    localparam int PLATE_W     = PLATE_CHARS * CHAR_W;

    function automatic logic [CHAR_W-1:0] get_char(input logic [PLATE_W-1:0] plate, input int k);
        return plate[k*CHAR_W +: CHAR_W];
    endfunction

endpackage

// File: rtl/plate_result_buf_if.sv
// plate_result_buf_if: plate capture input, pop handshake and status outputs
interface plate_result_buf_if
    import plate_pkg::*;
#(
    parameter int ADDR_W = 3,
    parameter int SEQ_W  = 8
);

    logic [PLATE_W-1:0] char_index_i;
    logic               char_valid_i;
    logic               clr;
    logic               rd_en;
    logic [PLATE_W-1:0] rd_data;
    logic [SEQ_W-1:0]   rd_seq;
    logic               rd_valid;
    logic [ADDR_W:0]    count;
    logic               full;
    logic [7:0]         drop_cnt;
    logic               new_irq;

    modport master (
        output char_index_i, char_valid_i, clr, rd_en,
        input  rd_data, rd_seq, rd_valid, count, full, drop_cnt, new_irq
    );

    modport slave (
        input  char_index_i, char_valid_i, clr, rd_en,
        output rd_data, rd_seq, rd_valid, count, full, drop_cnt, new_irq
    );

endinterface

// File: rtl/plate_fifo_mem.sv
// plate_fifo_mem: entry storage, one synchronous write port, one asynchronous read port
module plate_fifo_mem #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int W      = 36
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [W-1:0]      wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [W-1:0]      rdata
);

    logic [W-1:0] mem_q [DEPTH];

    // storage is deliberately not reset; control logic masks stale contents
    always_ff @(posedge clk) if (we) mem_q[waddr] <= wdata;

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/plate_result_buf.sv
// plate_result_buf: FWFT FIFO of sequence-tagged plate results with drop counter and irq pulse
module plate_result_buf
    import plate_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int SEQ_W  = 8
) (
    input  logic clk,
    input  logic rst_n,
    plate_result_buf_if.slave bus
);

    localparam int EW = PLATE_W + SEQ_W;

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic [7:0]        drop_q, drop_d;
    logic              rd_valid_q, rd_valid_d, full_q, full_d, irq_q, irq_d;
    logic              pop, push, drop, we;
    logic [EW-1:0]     head;

    // a pop frees a slot in the same cycle, so a full FIFO can still accept a push
    always_comb begin
        pop        = bus.rd_en && rd_valid_q;
        push       = bus.char_valid_i && (!full_q || pop);
        drop       = bus.char_valid_i && full_q && !pop;
        we         = push && !bus.clr;
        wr_ptr_d   = bus.clr ? '0 : wr_ptr_q + ADDR_W'(push);
        rd_ptr_d   = bus.clr ? '0 : rd_ptr_q + ADDR_W'(pop);
        count_d    = bus.clr ? '0 : count_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
        seq_d      = bus.clr ? '0 : seq_q + SEQ_W'(bus.char_valid_i);
        drop_d     = bus.clr ? '0 : drop_q + 8'(drop && drop_q != 8'hff);
        rd_valid_d = count_d != '0;
        full_d     = count_d == (ADDR_W+1)'(DEPTH);
        irq_d      = we;
    end

    // control state, asynchronously cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            seq_q      <= '0;
            drop_q     <= '0;
            rd_valid_q <= 1'b0;
            full_q     <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            seq_q      <= seq_d;
            drop_q     <= drop_d;
            rd_valid_q <= rd_valid_d;
            full_q     <= full_d;
            irq_q      <= irq_d;
        end
    end

    plate_fifo_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .W(EW)) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr_q),
        .wdata ({bus.char_index_i, seq_q}),
        .raddr (rd_ptr_q),
        .rdata (head)
    );

    assign bus.rd_data  = rd_valid_q ? head[EW-1:SEQ_W] : '0;
    assign bus.rd_seq   = rd_valid_q ? head[SEQ_W-1:0] : '0;
    assign bus.rd_valid = rd_valid_q;
    assign bus.count    = count_q;
    assign bus.full     = full_q;
    assign bus.drop_cnt = drop_q;
    assign bus.new_irq  = irq_q;

endmodule

// File: tb/tb_plate_result_buf.sv
// tb_plate_result_buf: randomized scoreboard bench against a queue-based reference model
module tb_plate_result_buf;
    import plate_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    plate_result_buf_if #(.ADDR_W(3), .SEQ_W(8)) bus();

    plate_result_buf #(.DEPTH(8), .ADDR_W(3), .SEQ_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [35:0] sb[$];
    int occ = 0;
    int mseq = 0;
    int mdrop = 0;
    bit mirq = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: compares every cycle away from the edge, retires the head on an accepted pop
    always @(negedge clk) begin
        if (rst_n) begin
            chk("count", 32'(bus.count), 32'(occ));
            chk("full", 32'(bus.full), 32'(occ == 8));
            chk("rd_valid", 32'(bus.rd_valid), 32'(occ != 0));
            chk("drop_cnt", 32'(bus.drop_cnt), 32'(mdrop));
            chk("new_irq", 32'(bus.new_irq), 32'(mirq));
            if (sb.size() != 0) begin
                chk("rd_data", 32'(bus.rd_data), 32'(sb[0][35:8]));
                chk("rd_seq", 32'(bus.rd_seq), 32'(sb[0][7:0]));
                if (bus.rd_en && !bus.clr) void'(sb.pop_front());
            end else begin
                chk("rd_data_empty", 32'(bus.rd_data), 32'h0);
                chk("rd_seq_empty", 32'(bus.rd_seq), 32'h0);
            end
        end
    end

    function automatic logic [27:0] rp();
        return 28'($urandom);
    endfunction

    task automatic model_reset();
        sb.delete();
        occ = 0;
        mseq = 0;
        mdrop = 0;
        mirq = 1'b0;
    endtask

    // drives one cycle of stimulus, then advances the reference model past the edge
    task automatic cyc(input bit cv, input logic [27:0] d, input bit re, input bit cl);
        bit p;
        bus.char_valid_i = cv;
        bus.char_index_i = d;
        bus.rd_en = re;
        bus.clr = cl;
        @(posedge clk);
        #1;
        if (cl) begin
            model_reset();
        end else begin
            p = re && occ > 0;
            mirq = cv && (occ < 8 || p);
            if (mirq) begin
                sb.push_back({d, 8'(mseq)});
                occ++;
            end else if (cv && mdrop < 255) begin
                mdrop++;
            end
            if (cv) mseq = (mseq + 1) % 256;
            if (p) occ--;
        end
        bus.char_valid_i = 1'b0;
        bus.rd_en = 1'b0;
        bus.clr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bus.char_valid_i = 1'b0;
        bus.char_index_i = '0;
        bus.rd_en = 1'b0;
        bus.clr = 1'b0;
        #23 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_count", 32'(bus.count), 32'h0);
        chk("reset_valid", 32'(bus.rd_valid), 32'h0);

        cyc(1'b1, 28'h1234567, 1'b0, 1'b0);
        chk("single_data", 32'(bus.rd_data), 32'h1234567);
        chk("single_seq", 32'(bus.rd_seq), 32'h0);
        chk("single_irq", 32'(bus.new_irq), 32'h1);
        idle(1);
        chk("single_irq_once", 32'(bus.new_irq), 32'h0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("single_popped", 32'(bus.rd_valid), 32'h0);
        chk("single_masked", 32'(bus.rd_data), 32'h0);

        cyc(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) cyc(1'b1, rp(), 1'b0, 1'b0);
        chk("fill_count", 32'(bus.count), 32'h8);
        chk("fill_full", 32'(bus.full), 32'h1);
        chk("fill_drop", 32'(bus.drop_cnt), 32'h2);
        cyc(1'b1, 28'hABCDEF0, 1'b1, 1'b0);
        chk("fullpp_count", 32'(bus.count), 32'h8);
        chk("fullpp_drop", 32'(bus.drop_cnt), 32'h2);
        for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        chk("drain_valid", 32'(bus.rd_valid), 32'h0);
        cyc(1'b1, 28'h0FEDCBA, 1'b1, 1'b0);
        chk("emptypp_count", 32'(bus.count), 32'h1);
        idle(1);

        cyc(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 300; i++) begin
            cyc(1'b1, rp(), 1'b1, 1'b0);
            if (i == 256) chk("wrap_seq", 32'(bus.rd_seq), 32'h0);
        end
        idle(2);

        for (int i = 0; i < 500; i++)
            cyc(bit'($urandom_range(0, 9) < 6), rp(), bit'($urandom_range(0, 9) < 4),
                bit'($urandom_range(0, 63) == 0));
        for (int i = 0; i < 9; i++) cyc(1'b0, '0, 1'b1, 1'b0);

        for (int i = 0; i < 268; i++) cyc(1'b1, rp(), 1'b0, 1'b0);
        chk("sat_drop", 32'(bus.drop_cnt), 32'hFF);
        cyc(1'b1, rp(), 1'b0, 1'b1);
        chk("clr_count", 32'(bus.count), 32'h0);
        chk("clr_drop", 32'(bus.drop_cnt), 32'h0);
        chk("clr_irq", 32'(bus.new_irq), 32'h0);
        cyc(1'b1, 28'h7654321, 1'b0, 1'b0);
        chk("clr_next_seq", 32'(bus.rd_seq), 32'h0);
        chk("clr_next_data", 32'(bus.rd_data), 32'h7654321);
        idle(1);

        cyc(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b1, rp(), 1'b0, 1'b0);
        chk("pre_rst_count", 32'(bus.count), 32'h5);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_valid", 32'(bus.rd_valid), 32'h0);
        chk("arst_count", 32'(bus.count), 32'h0);
        chk("arst_full", 32'(bus.full), 32'h0);
        chk("arst_drop", 32'(bus.drop_cnt), 32'h0);
        chk("arst_irq", 32'(bus.new_irq), 32'h0);
        chk("arst_data", 32'(bus.rd_data), 32'h0);
        chk("arst_seq", 32'(bus.rd_seq), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_valid", 32'(bus.rd_valid), 32'h0);
        chk("post_rst_count", 32'(bus.count), 32'h0);
        cyc(1'b1, 28'h1111111, 1'b0, 1'b0);
        chk("post_rst_seq", 32'(bus.rd_seq), 32'h0);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/plate_result_buf.md
Name: plate_result_buf

Overview:
- Downstream consumer of the plate-judge stage. It captures each accepted plate result (7 chars × 4 bits, qualified by a 1-cycle valid pulse) into a small first-word-fall-through FIFO.
- The Cortex-M3 side drains the FIFO through a pop handshake.
- Each entry is tagged with a sequence number, so software can detect dropped plates.
- Also provides a drop counter and a new-result pulse for the interrupt controller.

Parameters:
- DEPTH, 8, FIFO entries; must be a power of two, ≥2.
- ADDR_W, 3, log2(DEPTH).
- SEQ_W, 8, width of the per-plate sequence tag.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- char_index_i  in  28  plate result, char k at bits [4k+3:4k].
- char_valid_i  in  1  1-cycle pulse; char_index_i is valid in that cycle.
- clr  in  1  synchronous soft clear, from a CPU register write.
- rd_en  in  1  pop request; honoured only when rd_valid=1.
- rd_data  out  28  plate at the FIFO head.
- rd_seq  out  SEQ_W  sequence tag of the head entry.
- rd_valid  out  1  FIFO non-empty; rd_data/rd_seq are meaningful.
- count  out  ADDR_W+1  number of stored entries, 0..DEPTH.
- full  out  1  count==DEPTH.
- drop_cnt  out  8  plates lost because the FIFO was full; saturates at 255.
- new_irq  out  1  1-cycle pulse for each plate written.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - wr_ptr, rd_ptr, count, seq_ctr and drop_cnt go to 0.
  - rd_valid=0, full=0, new_irq=0.
  - rd_data and rd_seq read as 0 while empty: outputs are masked to 0 when rd_valid=0.
  - Storage array contents are not reset.
- Sequence counter:
  - seq_ctr increments by 1 on every char_valid_i, whether the plate is stored or dropped.
  - Wraps from 2^SEQ_W−1 to 0.
  - The stored tag is the seq_ctr value before the increment, so the first plate after reset is tagged 0.
- Push (char_valid_i=1 at edge k):
  - If not full, or a pop is accepted in the same cycle, then {char_index_i, seq_ctr} is written at wr_ptr and wr_ptr++ (mod DEPTH).
  - new_irq=1 during cycle k+1 only.
- Drop:
  - If full and no pop that cycle, the new plate is discarded and the oldest entries are kept.
  - drop_cnt++ (saturates at 255). new_irq stays 0.
- Pop (rd_en=1 and rd_valid=1 at edge k): rd_ptr++ and the next head appears in cycle k+1.
  - rd_en while empty is ignored: no pointer move, no error.
- Latency and read path:
  - A push into an empty FIFO at edge k gives rd_valid=1 with rd_data/rd_seq valid in cycle k+1. This is first-word fall-through.
  - Storage is read asynchronously at rd_ptr.
- count update per edge:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push+pop, or on drop.
  - Derived signals: rd_valid = (count≠0), full = (count==DEPTH), both registered consistently with count.
- Simultaneous events:
  - Push+pop when empty: push succeeds and pop is ignored (rd_valid was 0), so count=1.
  - Push+pop when full: both succeed, count stays DEPTH and there is no drop.
- Wrap-around: pointers are ADDR_W bits and wrap naturally. count disambiguates full from empty.
- clr:
  - Has priority over push and pop in the same cycle.
  - Zeroes pointers, count, seq_ctr and drop_cnt.
  - new_irq=0 in the next cycle.
  - A plate arriving in the clr cycle is discarded and not counted.
- Reset mid-operation: asynchronous return to the reset state; no partial entry is visible after reset release.

Decomposition:
- Shared package plate_pkg:
  - PLATE_CHARS=7, CHAR_W=4, PLATE_W=28.
  - The char-field extraction function, char(k).
  - Reused by the judge, display and bus-register blocks.
- Sub-module plate_fifo_mem:
  - DEPTH × (PLATE_W+SEQ_W) register array.
  - One synchronous write port and one asynchronous read port.
  - Control logic stays in plate_result_buf.

Test Plan:
- Single plate: after reset, pulse char_valid_i with 28'h1234567.
  - Next cycle: rd_valid=1, rd_data=28'h1234567, rd_seq=0, count=1, one new_irq pulse.
  - Pop it: next cycle rd_valid=0, rd_data=0.
- Fill and overflow: push 10 plates with no pops (DEPTH=8).
  - Result: count=8, full=1, drop_cnt=2.
  - Popping all 8 yields seq 0..7 in order, then rd_valid=0.
- Push+pop at boundaries:
  - Full FIFO, push+pop in the same cycle: count stays 8, drop_cnt unchanged, new tail seq correct.
  - Empty FIFO, push+pop in the same cycle: count=1.
- Wrap-around: run 300 push/pop pairs.
  - rd_seq wraps 255→0 (the 257th plate is tagged 0).
  - Data matches the scoreboard throughout; pointer wrap shows no corruption.
- Saturation and clr:
  - 260 drops while full gives drop_cnt=255.
  - clr asserted together with char_valid_i: count=0, drop_cnt=0, the next plate is tagged seq 0, and no new_irq for the discarded plate.
- Asynchronous reset with 5 entries stored: assert rst_n low mid-cycle.
  - Outputs go to reset values immediately.
  - After release, rd_valid=0 and count=0.
